serial_frame_rx: RTL and testbench

- Receives a framed, LSB-first serial bitstream and assembles N-bit words.
- Sits directly upstream of the team's parallel-load shift register; its data/out_valid pair drives that register's parallel-input path.
- Framing: start bit 0, N data bits, optional parity bit, stop bit 1; idle line level is 1.
- Output side is a single-entry holding register with a valid/ready handshake.

---
 rtl/serial_frame_rx.sv | 190 +++++++++++++++++++
 tb/tb_serial_frame_rx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: framed LSB-first serial receiver feeding a single-entry valid/ready holding register.
// Define SERIAL_FRAME_RX_PARITY_EN to add an even-parity bit after the data bits and the parity_err output.
module serial_frame_rx #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin,
    input  logic         bit_en,
    input  logic         out_ready,
    output logic [N-1:0] data,
    output logic         out_valid,
    output logic         busy,
    output logic         frame_err,
`ifdef SERIAL_FRAME_RX_PARITY_EN
    output logic         parity_err,
`endif
    output logic         overrun
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
`ifdef SERIAL_FRAME_RX_PARITY_EN
        ST_PAR  = 2'd2,
`endif
        ST_STOP = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [N-1:0]  sh_r;
    logic [CW-1:0] cnt_r;
    logic          deliver_s;
    logic          frame_err_s;
    logic [N-1:0]  data_r;
    logic          out_valid_r;
    logic          busy_r;
    logic          frame_err_r;
    logic          overrun_r;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic          par_r;
    logic          parity_fail_s;
    logic          parity_err_r;

    // Even parity: data bits XOR parity bit must be zero.
    function automatic logic even_parity_ok(input logic [N-1:0] w, input logic p);
        return ~((^w) ^ p);
    endfunction
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; the FSM only moves on bit_en strobes.
    always_comb begin
        state_nxt_s = state_r;
        if (bit_en) begin
            case (state_r)
                ST_IDLE: begin
                    if (!sin) begin
                        state_nxt_s = ST_DATA;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (cnt_r == CNT_LAST) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        state_nxt_s = ST_PAR;
`else
                        state_nxt_s = ST_STOP;
`endif
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end
`ifdef SERIAL_FRAME_RX_PARITY_EN
                ST_PAR:  state_nxt_s = ST_PAR == state_r ? ST_STOP : ST_IDLE;
`endif
                ST_STOP: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Bit counter, shift register and parity capture; all hold between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_r  <= {N{1'b0}};
            cnt_r <= {CW{1'b0}};
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_r <= 1'b0;
`endif
        end else if (bit_en) begin
            case (state_r)
                ST_IDLE: begin
                    if (!sin) begin
                        cnt_r <= {CW{1'b0}};
                    end
                end
                ST_DATA: begin
                    sh_r <= {sin, sh_r[N-1:1]};
                    if (cnt_r != CNT_LAST) begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
`ifdef SERIAL_FRAME_RX_PARITY_EN
                ST_PAR:  par_r <= sin;
`endif
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Frame completion decode at the stop-bit strobe.
    always_comb begin
        deliver_s   = 1'b0;
        frame_err_s = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        parity_fail_s = 1'b0;
`endif
        if (bit_en && (state_r == ST_STOP)) begin
            if (sin) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                if (even_parity_ok(sh_r, par_r)) begin
                    deliver_s = 1'b1;
                end else begin
                    parity_fail_s = 1'b1;
                end
`else
                deliver_s = 1'b1;
`endif
            end else begin
                frame_err_s = 1'b1;
            end
        end else begin
            deliver_s   = 1'b0;
            frame_err_s = 1'b0;
        end
    end

    // Holding register, handshake and registered status pulses; evaluated every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r      <= {N{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
        end else begin
            busy_r      <= (state_nxt_s != ST_IDLE);
            frame_err_r <= frame_err_s;
            overrun_r   <= deliver_s & out_valid_r & ~out_ready;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            parity_err_r <= parity_fail_s;
`endif
            if (deliver_s && (!out_valid_r || out_ready)) begin
                data_r      <= sh_r;
                out_valid_r <= 1'b1;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign data      = data_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    assign parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: directed table, corner sequences and random frames
// checked every cycle against a frame-level reference model.
module tb_serial_frame_rx;

    localparam int N = 4;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam int NB = N + 3;
`else
    localparam int NB = N + 2;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         sin;
    logic         bit_en;
    logic         out_ready;
    logic [N-1:0] data;
    logic         out_valid;
    logic         busy;
    logic         frame_err;
    logic         overrun;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic         parity_err;
`endif

    int tests  = 0;
    int failed = 0;

    // Reference model state: the word the consumer should currently see.
    logic         mv;
    logic [N-1:0] md;

    typedef struct {
        logic [N-1:0] word;
        logic         stop;
        logic         rdy_at_stop;
        logic         drain;
        logic [N-1:0] exp_data;
        logic         exp_valid;
        logic         exp_fe;
        logic         exp_ov;
    } vec_t;

    vec_t vecs[7];

    serial_frame_rx #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .bit_en    (bit_en),
        .out_ready (out_ready),
        .data      (data),
        .out_valid (out_valid),
        .busy      (busy),
        .frame_err (frame_err),
`ifdef SERIAL_FRAME_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic pick_rdy(input int rmode);
        if (rmode == 0) return 1'b0;
        else if (rmode == 1) return 1'b1;
        else return 1'($urandom_range(1, 0));
    endfunction

    // One clock: drive inputs, predict outputs, compare. ev: 0 none, 1 good stop, 2 bad stop, 3 bad parity.
    task automatic cyc(input logic s, input logic en, input logic rdy, input int ev,
                       input logic [N-1:0] w, input logic busy_after);
        logic e_fe, e_pe, e_ov;
        sin = s; bit_en = en; out_ready = rdy;
        e_fe = en && (ev == 2);
        e_pe = en && (ev == 3);
        e_ov = en && (ev == 1) && mv && !rdy;
        if (en && (ev == 1) && (!mv || rdy)) begin
            md = w;
            mv = 1'b1;
        end else if (mv && rdy) begin
            mv = 1'b0;
        end
        @(posedge clk); #1;
        check("data",      32'(data),      32'(md));
        check("out_valid", 32'(out_valid), 32'(mv));
        check("busy",      32'(busy),      32'(busy_after));
        check("frame_err", 32'(frame_err), 32'(e_fe));
        check("overrun",   32'(overrun),   32'(e_ov));
`ifdef SERIAL_FRAME_RX_PARITY_EN
        check("parity_err", 32'(parity_err), 32'(e_pe));
`else
        if (e_pe) check("no_parity_event", 32'(e_pe), 32'(0));
`endif
    endtask

    // Sends start, data LSB first, optional parity, stop; gap non-strobe cycles before each bit.
    task automatic send_frame(input logic [N-1:0] w, input logic stop, input logic par_good,
                              input int gap, input int rmode, input logic rdy_at_stop);
        logic [NB-1:0] bits;
        logic last, rdy;
        int ev;
        bits[0] = 1'b0;
        for (int i = 0; i < N; i++) bits[1+i] = w[i];
`ifdef SERIAL_FRAME_RX_PARITY_EN
        bits[N+1] = par_good ? (^w) : ~(^w);
`endif
        bits[NB-1] = stop;
        for (int i = 0; i < NB; i++) begin
            for (int g = 0; g < gap; g++)
                cyc(1'($urandom_range(1, 0)), 1'b0, pick_rdy(rmode), 0, w, i != 0);
            last = (i == NB - 1);
`ifdef SERIAL_FRAME_RX_PARITY_EN
            ev = !last ? 0 : (!stop ? 2 : (par_good ? 1 : 3));
`else
            ev = !last ? 0 : (stop ? 1 : 2);
`endif
            rdy = (last && rmode == 0) ? rdy_at_stop : pick_rdy(rmode);
            cyc(bits[i], 1'b1, rdy, ev, w, !last);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //            word   stop  rdy@stop drain exp_data valid fe    ov
        vecs[0] = '{4'b1101, 1'b1, 1'b0, 1'b1, 4'b1101, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b1101, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{4'hA,    1'b1, 1'b0, 1'b0, 4'hA,    1'b1, 1'b0, 1'b0};
        vecs[4] = '{4'h3,    1'b1, 1'b0, 1'b1, 4'hA,    1'b1, 1'b0, 1'b1};
        vecs[5] = '{4'hC,    1'b1, 1'b0, 1'b0, 4'hC,    1'b1, 1'b0, 1'b0};
        vecs[6] = '{4'h5,    1'b1, 1'b1, 1'b1, 4'h5,    1'b1, 1'b0, 1'b0};

        rst = 1'b1; sin = 1'b1; bit_en = 1'b0; out_ready = 1'b0;
        mv = 1'b0; md = '0;
        #1;
        check("rst_data",  32'(data),      32'(0));
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_busy",  32'(busy),      32'(0));
        check("rst_fe",    32'(frame_err), 32'(0));
        check("rst_ov",    32'(overrun),   32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Idle line with sparse strobes must stay idle.
        for (int i = 0; i < 20; i++) cyc(1'b1, (i % 4) == 0, 1'b0, 0, '0, 1'b0);

        // Directed table.
        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].word, vecs[v].stop, 1'b1, 1, 0, vecs[v].rdy_at_stop);
            check("tbl_data",  32'(data),      32'(vecs[v].exp_data));
            check("tbl_valid", 32'(out_valid), 32'(vecs[v].exp_valid));
            check("tbl_fe",    32'(frame_err), 32'(vecs[v].exp_fe));
            check("tbl_ov",    32'(overrun),   32'(vecs[v].exp_ov));
            if (vecs[v].drain) begin
                cyc(1'b1, 1'b0, 1'b1, 0, '0, 1'b0);
                check("tbl_drain_valid", 32'(out_valid), 32'(0));
                check("tbl_drain_data",  32'(data),      32'(vecs[v].exp_data));
            end
        end

        // Mid-frame reset with a word pending: outputs clear immediately.
        send_frame(4'h9, 1'b1, 1'b1, 0, 0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 0, '0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 0, '0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 0, '0, 1'b1);
        bit_en = 1'b0; sin = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_data",  32'(data),      32'(0));
        check("mid_rst_valid", 32'(out_valid), 32'(0));
        check("mid_rst_busy",  32'(busy),      32'(0));
        md = '0; mv = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        send_frame(4'h6, 1'b1, 1'b1, 1, 0, 1'b0);
        check("post_rst_data", 32'(data), 32'(6));
        cyc(1'b1, 1'b0, 1'b1, 0, '0, 1'b0);

`ifdef SERIAL_FRAME_RX_PARITY_EN
        send_frame(4'b0111, 1'b1, 1'b0, 1, 0, 1'b0);
        check("par_bad_pulse", 32'(parity_err), 32'(1));
        check("par_bad_valid", 32'(out_valid),  32'(0));
        send_frame(4'b0111, 1'b1, 1'b1, 1, 0, 1'b0);
        check("par_good_data",  32'(data),      32'(7));
        check("par_good_valid", 32'(out_valid), 32'(1));
        cyc(1'b1, 1'b0, 1'b1, 0, '0, 1'b0);
`endif

        // Random frames, gaps, errors and consumer backpressure.
        for (int f = 0; f < 80; f++) begin
            send_frame(N'($urandom), ($urandom % 8) != 0, ($urandom % 8) != 0,
                       int'($urandom_range(3, 0)), 2, 1'b0);
            if (($urandom % 4) == 0) cyc(1'b1, 1'b1, pick_rdy(2), 0, '0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
